// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the producers, the write arbiter and the fifo write port.
// The arbiter side uses master (it masters the fifo write port); the environment uses slave.
interface fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               flush_req;
  logic               flush_done;
  logic               fifo_full;
  logic               fifo_wren;
  logic [DW-1:0]      fifo_din;
  logic               fifo_sclr;
  logic [2:0]         grant_id;

  modport master (
    input  req_valid, req_data, flush_req, fifo_full,
    output req_ready, flush_done, fifo_wren, fifo_din, fifo_sclr, grant_id
  );

  modport slave (
    output req_valid, req_data, flush_req, fifo_full,
    input  req_ready, flush_done, fifo_wren, fifo_din, fifo_sclr, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with per-grant burst limit and a flush sequencer
// (one-cycle sclr pulse, then one-cycle done pulse) in front of an 8-bit fifo.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input logic               clk,
  input logic               reset,
  fifo_wr_arbiter_if.master bus
);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  state_t        state, state_next;
  logic [2:0]    last;
  logic [3:0]    bcnt;
  logic [2:0]    grant_id_q;

  logic [7:0]    valid8;
  logic [DW-1:0] data_arr [8];
  logic          gnt_found;
  logic          gnt_hold;
  logic [2:0]    gnt_idx;
  logic [3:0]    cand;
  logic          grant_en;

  // Widen the request side to eight slots so 3-bit indices never go out of range.
  always_comb begin
    valid8 = '0;
    valid8[NREQ-1:0] = bus.req_valid;
    for (int i = 0; i < 8; i++) data_arr[i] = '0;
    for (int i = 0; i < NREQ; i++) data_arr[i] = bus.req_data[i*DW +: DW];
  end

  // Burst hold on last, else search last+1 .. last (last itself is the final candidate).
  always_comb begin
    gnt_found = 1'b0;
    gnt_hold  = 1'b0;
    gnt_idx   = last;
    cand      = '0;
    if (valid8[last] && (bcnt < 4'(BURST))) begin
      gnt_found = 1'b1;
      gnt_hold  = 1'b1;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = {1'b0, last} + 4'(k);
        if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
        if (!gnt_found && valid8[cand[2:0]]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand[2:0];
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (bus.flush_req) state_next = FLUSH;
      FLUSH:   state_next = DONE;
      DONE:    state_next = RUN;
      default: state_next = RUN;
    endcase

    // A flush request in RUN wins over any pending write in the same cycle.
    grant_en = !reset && (state == RUN) && !bus.flush_req && !bus.fifo_full && gnt_found;

    for (int i = 0; i < NREQ; i++) bus.req_ready[i] = grant_en && (gnt_idx == 3'(i));
    bus.fifo_wren  = grant_en;
    bus.fifo_din   = grant_en ? data_arr[gnt_idx] : '0;
    bus.fifo_sclr  = (state == FLUSH);
    bus.flush_done = (state == DONE);
  end

  // A search-path grant restarts the burst count, even when it lands on last again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      last       <= 3'(NREQ - 1);
      bcnt       <= '0;
      grant_id_q <= '0;
    end else begin
      state <= state_next;
      if (grant_en) begin
        bcnt       <= gnt_hold ? bcnt + 4'd1 : 4'd1;
        last       <= gnt_idx;
        grant_id_q <= gnt_idx;
      end
    end
  end

  assign bus.grant_id = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-cycle vector table plus reset/flush
// corner sequences; written words are checked in order against a scoreboard queue.
module tb_fifo_wr_arbiter;

  localparam logic [31:0] D = 32'h44332211;

  typedef struct {
    logic [3:0]  valid;
    logic        full;
    logic        flush;
    logic [31:0] data;
    logic [3:0]  ready;
    logic        wren;
    logic [7:0]  din;
    logic [2:0]  gid;
    logic        sclr;
    logic        done;
  } vec_t;

  logic clk;
  logic reset;
  int   tests;
  int   failed;
  logic [7:0] exp_q [$];
  vec_t vecs [$];

  fifo_wr_arbiter_if #(.NREQ(4), .DW(8)) bus ();

  fifo_wr_arbiter #(.NREQ(4), .DW(8), .BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] valid, input logic full, input logic flush,
                              input logic [31:0] data, input logic [3:0] ready, input logic wren,
                              input logic [7:0] din, input logic [2:0] gid, input logic sclr,
                              input logic done);
    vec_t v;
    v.valid = valid; v.full = full; v.flush = flush; v.data = data;
    v.ready = ready; v.wren = wren; v.din = din; v.gid = gid; v.sclr = sclr; v.done = done;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    @(posedge clk);
    #1;
    bus.req_valid = v.valid;
    bus.fifo_full = v.full;
    bus.flush_req = v.flush;
    bus.req_data  = v.data;
    if (v.wren) exp_q.push_back(v.din);
    #1;
    check_output($sformatf("v%0d_ready", idx), 32'(bus.req_ready), 32'(v.ready));
    check_output($sformatf("v%0d_wren", idx), 32'(bus.fifo_wren), 32'(v.wren));
    check_output($sformatf("v%0d_din", idx), 32'(bus.fifo_din), 32'(v.din));
    check_output($sformatf("v%0d_gid", idx), 32'(bus.grant_id), 32'(v.gid));
    check_output($sformatf("v%0d_sclr", idx), 32'(bus.fifo_sclr), 32'(v.sclr));
    check_output($sformatf("v%0d_done", idx), 32'(bus.flush_done), 32'(v.done));
  endtask

  // Every word the fifo takes must be the oldest expected beat.
  always @(negedge clk) begin
    if (bus.fifo_wren === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_output("sb_unexpected_write", 32'(bus.fifo_din), 32'hFFFF_FFFF);
      end else begin
        check_output("sb_word", 32'(bus.fifo_din), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = D;
    bus.fifo_full = 1'b0;
    bus.flush_req = 1'b0;

    //              valid    full  fl    data            ready    wr    din    gid   sclr  done
    vecs.push_back(mk(4'b0000, 1'b0, 1'b0, D,            4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0101, 1'b0, 1'b0, D,            4'b0001, 1'b1, 8'h11, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0101, 1'b0, 1'b0, D,            4'b0001, 1'b1, 8'h11, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0101, 1'b0, 1'b0, D,            4'b0001, 1'b1, 8'h11, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0101, 1'b0, 1'b0, D,            4'b0001, 1'b1, 8'h11, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0101, 1'b0, 1'b0, D,            4'b0100, 1'b1, 8'h33, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0101, 1'b0, 1'b0, D,            4'b0100, 1'b1, 8'h33, 3'd2, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0101, 1'b0, 1'b0, D,            4'b0100, 1'b1, 8'h33, 3'd2, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0101, 1'b0, 1'b0, D,            4'b0100, 1'b1, 8'h33, 3'd2, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0101, 1'b0, 1'b0, D,            4'b0001, 1'b1, 8'h11, 3'd2, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0010, 1'b0, 1'b0, 32'h44335111, 4'b0010, 1'b1, 8'h51, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0010, 1'b1, 1'b0, 32'h44335211, 4'b0000, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0010, 1'b1, 1'b0, 32'h44335211, 4'b0000, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0010, 1'b1, 1'b0, 32'h44335211, 4'b0000, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0010, 1'b0, 1'b0, 32'h44335211, 4'b0010, 1'b1, 8'h52, 3'd1, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0010, 1'b0, 1'b0, 32'h44335311, 4'b0010, 1'b1, 8'h53, 3'd1, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0010, 1'b0, 1'b0, 32'h44335411, 4'b0010, 1'b1, 8'h54, 3'd1, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0010, 1'b0, 1'b0, 32'h44335511, 4'b0010, 1'b1, 8'h55, 3'd1, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1000, 1'b0, 1'b1, D,            4'b0000, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1000, 1'b0, 1'b1, D,            4'b0000, 1'b0, 8'h00, 3'd1, 1'b1, 1'b0));
    vecs.push_back(mk(4'b1000, 1'b0, 1'b0, D,            4'b0000, 1'b0, 8'h00, 3'd1, 1'b0, 1'b1));
    vecs.push_back(mk(4'b1000, 1'b0, 1'b0, D,            4'b1000, 1'b1, 8'h44, 3'd1, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 1'b0, D,            4'b0000, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1111, 1'b0, 1'b0, D,            4'b1000, 1'b1, 8'h44, 3'd3, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1111, 1'b0, 1'b0, D,            4'b1000, 1'b1, 8'h44, 3'd3, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1111, 1'b0, 1'b0, D,            4'b1000, 1'b1, 8'h44, 3'd3, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1111, 1'b0, 1'b0, D,            4'b0001, 1'b1, 8'h11, 3'd3, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0110, 1'b0, 1'b0, D,            4'b0010, 1'b1, 8'h22, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0110, 1'b1, 1'b1, D,            4'b0000, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0110, 1'b0, 1'b0, D,            4'b0000, 1'b0, 8'h00, 3'd1, 1'b1, 1'b0));
    vecs.push_back(mk(4'b0110, 1'b0, 1'b1, D,            4'b0000, 1'b0, 8'h00, 3'd1, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0110, 1'b0, 1'b0, D,            4'b0010, 1'b1, 8'h22, 3'd1, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0111, 1'b0, 1'b0, D,            4'b0010, 1'b1, 8'h22, 3'd1, 1'b0, 1'b0));

    #2;
    check_output("rst_ready", 32'(bus.req_ready), 32'h0);
    check_output("rst_wren", 32'(bus.fifo_wren), 32'h0);
    check_output("rst_sclr", 32'(bus.fifo_sclr), 32'h0);
    check_output("rst_done", 32'(bus.flush_done), 32'h0);
    check_output("rst_gid", 32'(bus.grant_id), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i], i);

    // Async reset in the middle of requester 1's burst.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_output("midburst_ready", 32'(bus.req_ready), 32'h0);
    check_output("midburst_wren", 32'(bus.fifo_wren), 32'h0);
    check_output("midburst_din", 32'(bus.fifo_din), 32'h0);
    check_output("midburst_gid", 32'(bus.grant_id), 32'h0);
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply_stimulus(mk(4'b0111, 1'b0, 1'b0, D, 4'b0001, 1'b1, 8'h11, 3'd0, 1'b0, 1'b0), 100);
    apply_stimulus(mk(4'b0111, 1'b0, 1'b0, D, 4'b0001, 1'b1, 8'h11, 3'd0, 1'b0, 1'b0), 101);

    // Async reset while in FLUSH: no done pulse afterwards.
    apply_stimulus(mk(4'b0000, 1'b0, 1'b1, D, 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0), 102);
    @(posedge clk);
    #1;
    bus.flush_req = 1'b0;
    check_output("midflush_sclr_pre", 32'(bus.fifo_sclr), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    check_output("midflush_sclr", 32'(bus.fifo_sclr), 32'h0);
    check_output("midflush_done", 32'(bus.flush_done), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply_stimulus(mk(4'b0000, 1'b0, 1'b0, D, 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0), 103);
    apply_stimulus(mk(4'b0000, 1'b0, 1'b0, D, 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0), 104);

    @(posedge clk);
    #1;
    check_output("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
